// File: rtl/proc_defs.sv
// Shared opcode, register-file source and sequencer state definitions
// for the 16-bit processor.
package proc_defs;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_NOT   = 4'd6;
  localparam logic [3:0] OP_CLEAR = 4'd7;
  localparam logic [3:0] OP_MOVE  = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_PRINT = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_RAM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_MEM   = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_JMP;
  endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter: async reset to zero, JMP load has priority over increment,
// increment wraps modulo 2^PC_W.
module prog_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/decode/execute controller: owns the pc, latches instructions and issues
// one-cycle datapath strobes. Define SINGLE_STEP_EN to add the step port.
module program_sequencer
  import proc_defs::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [PC_W-1:0]    addr_p,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         alu_op,
  output logic [3:0]         reg_sel,
  output logic [7:0]         imm,
  output logic [1:0]         src_sel,
  output logic               rf_we,
  output logic               ram_we,
  output logic [7:0]         ram_addr,
  output logic               print_en,
  output logic               halted
);

  state_t          state;
  state_t          boundary_state;
  logic            start_ok;
  logic [3:0]      fetched_op;
  logic [3:0]      ir_op;
  logic            pc_inc;
  logic            pc_load;
  logic [PC_W-1:0] pc;

  assign fetched_op = instr[15:12];
  assign ir_op      = ir[15:12];

`ifdef SINGLE_STEP_EN
  assign start_ok       = run & step;
  assign boundary_state = ST_IDLE;
`else
  assign start_ok       = run;
  assign boundary_state = run ? ST_FETCH : ST_IDLE;
`endif

  // pc moves only on the EXEC exit edge; an illegal opcode leaves it frozen
  assign pc_load = (state == ST_EXEC) && (ir_op == OP_JMP);
  assign pc_inc  = (state == ST_EXEC) && !op_illegal(ir_op) && (ir_op != OP_JMP);

  prog_counter #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (PC_W'(ir[7:0])),
    .pc       (pc)
  );

  assign addr_p   = pc;
  assign alu_op   = ir_op;
  assign reg_sel  = ir[11:8];
  assign imm      = ir[7:0];
  assign ram_addr = ir[7:0];

  // Strobes are decoded from the ROM word on the WAIT exit edge so they are
  // registered and line up exactly with the EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ir       <= '0;
      rf_we    <= 1'b0;
      ram_we   <= 1'b0;
      print_en <= 1'b0;
      src_sel  <= SRC_ALU;
      halted   <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      ram_we   <= 1'b0;
      print_en <= 1'b0;
      src_sel  <= SRC_ALU;
      case (state)
        ST_IDLE: begin
          if (start_ok) state <= ST_FETCH;
        end
        ST_FETCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          ir    <= instr;
          state <= ST_EXEC;
          case (fetched_op) inside
            [OP_ADD:OP_CLEAR]: rf_we <= 1'b1;
            OP_MOVE: begin
              rf_we   <= 1'b1;
              src_sel <= SRC_IMM;
            end
            OP_STORE: ram_we   <= 1'b1;
            OP_PRINT: print_en <= 1'b1;
            default: ;
          endcase
        end
        ST_EXEC: begin
          if (op_illegal(ir_op)) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (ir_op == OP_LOAD) begin
            state   <= ST_MEM;
            rf_we   <= 1'b1;
            src_sel <= SRC_RAM;
          end else begin
            state <= boundary_state;
          end
        end
        ST_MEM: begin
          state <= boundary_state;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: ISA-level reference model with a
// registered ROM, decode table vectors, directed corner sequences and random programs.
module tb_program_sequencer;

  typedef struct {
    logic [15:0] instr;
    logic        rf;
    logic [1:0]  src;
    logic        ram;
    logic        prn;
    logic        mem;
    logic        jmp;
  } exp_t;

`ifdef SINGLE_STEP_EN
  localparam bit STEP = 1'b1;
  logic step = 1'b0;
`else
  localparam bit STEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] instr = '0;
  logic [7:0]  addr_p;
  logic [15:0] ir;
  logic [3:0]  alu_op;
  logic [3:0]  reg_sel;
  logic [7:0]  imm;
  logic [1:0]  src_sel;
  logic        rf_we;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic        print_en;
  logic        halted;

  logic [15:0] rom [256];
  logic [7:0]  m_pc;
  logic [15:0] last_instr;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        tbl [12];

  program_sequencer #(.PC_W(8), .INSTR_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .instr    (instr),
`ifdef SINGLE_STEP_EN
    .step     (step),
`endif
    .addr_p   (addr_p),
    .ir       (ir),
    .alu_op   (alu_op),
    .reg_sel  (reg_sel),
    .imm      (imm),
    .src_sel  (src_sel),
    .rf_we    (rf_we),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .print_en (print_en),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Program ROM with registered address: one clock of read latency
  always @(posedge clk) instr <= rom[addr_p];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_step(input logic v);
`ifdef SINGLE_STEP_EN
    step = v;
`else
    if (v) ;
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (pc model %0h, t=%0t)", name, act, exp, m_pc, $time);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk(name, 32'({rf_we, ram_we, print_en, halted}), 32'd0);
  endtask

  // ISA rules: what one instruction word must do
  function automatic exp_t isa_expect(input logic [15:0] w);
    exp_t e;
    logic [3:0] op;
    op    = w[15:12];
    e.instr = w;
    e.rf  = (op >= 4'd1) && (op <= 4'd8);
    e.src = (op == 4'd8) ? 2'd1 : 2'd0;
    e.ram = (op == 4'd10);
    e.prn = (op == 4'd11);
    e.mem = (op == 4'd9);
    e.jmp = (op == 4'd12);
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    set_step(1'b0);
    repeat (2) @(negedge clk);
    chk("reset_addr_p", 32'(addr_p), 32'd0);
    chk("reset_ir", 32'(ir), 32'd0);
    chk("reset_src_sel", 32'(src_sel), 32'd0);
    chk_quiet("reset_strobes");
    reset = 1'b0;
    m_pc  = 8'd0;
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1;
    if (STEP) set_step(1'b1);
  endtask

  // Next negedge must be this instruction's FETCH cycle
  task automatic exec_checked(input exp_t e, input bit last);
    rom[m_pc] = e.instr;
    @(negedge clk);
    if (STEP) set_step(1'b0);
    chk("fetch_addr_p", 32'(addr_p), 32'(m_pc));
    chk_quiet("fetch_strobes");
    @(negedge clk);
    chk("wait_addr_p", 32'(addr_p), 32'(m_pc));
    chk_quiet("wait_strobes");
    if (last) run = 1'b0;
    if (STEP) set_step(1'b1);
    @(negedge clk);
    if (STEP) set_step(1'b0);
    chk("exec_ir", 32'(ir), 32'(e.instr));
    chk("exec_rf_we", 32'(rf_we), 32'(e.rf));
    if (e.rf) chk("exec_src_sel", 32'(src_sel), 32'(e.src));
    chk("exec_ram_we", 32'(ram_we), 32'(e.ram));
    chk("exec_print_en", 32'(print_en), 32'(e.prn));
    chk("exec_halted", 32'(halted), 32'd0);
    chk("exec_fields", 32'({alu_op, reg_sel, imm, ram_addr}),
        32'({e.instr[15:12], e.instr[11:8], e.instr[7:0], e.instr[7:0]}));
    if (e.mem) begin
      @(negedge clk);
      chk("mem_rf_we", 32'(rf_we), 32'd1);
      chk("mem_src_sel", 32'(src_sel), 32'd2);
      chk("mem_other", 32'({ram_we, print_en, halted}), 32'd0);
      chk("mem_ram_addr", 32'(ram_addr), 32'(e.instr[7:0]));
    end
    last_instr = e.instr;
    m_pc = e.jmp ? e.instr[7:0] : m_pc + 8'd1;
  endtask

  task automatic park();
    repeat (2) begin
      @(negedge clk);
      chk_quiet("idle_strobes");
      chk("idle_addr_p", 32'(addr_p), 32'(m_pc));
      chk("idle_fields_stable", 32'({alu_op, reg_sel, imm}), 32'(last_instr));
    end
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0 || STEP) start();
      exec_checked(isa_expect(rom[m_pc]), (i == n - 1) || STEP);
      if (i == n - 1 || STEP) park();
    end
  endtask

  initial begin
    tbl[0]  = '{16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'h1123, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{16'h2A00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'h7300, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h8455, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h9210, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{16'hA320, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{16'hB100, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{16'hC0FF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{16'hC000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{16'h8F01, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    m_pc = 8'd0;
    last_instr = 16'h0000;

    // Decode table, one instruction per run pulse; entries 8-10 cover wrap and self-JMP
    do_reset();
    for (int i = 0; i < 12; i++) begin
      start();
      exec_checked(tbl[i], 1'b1);
      park();
    end

    // MOVE/MOVE/ADD/PRINT/NOP then JMP 2 loop, free-running
    do_reset();
    rom[0] = 16'h8004; rom[1] = 16'h8105; rom[2] = 16'h1000;
    rom[3] = 16'hB000; rom[4] = 16'h0000; rom[5] = 16'hC002;
    run_seq(10);
    chk("jmp_loop_end_pc", 32'(addr_p), 32'd2);

    // LOAD at pc 7 then STORE
    do_reset();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'hC007; rom[7] = 16'h9310; rom[8] = 16'hA120;
    run_seq(4);
    chk("load_seq_end_pc", 32'(addr_p), 32'd10);

    // Illegal opcode at pc 3 traps and freezes
    do_reset();
    rom[0] = 16'hC003; rom[3] = 16'hE000;
    start();
    exec_checked(isa_expect(rom[0]), STEP);
    if (STEP) start();
    @(negedge clk);
    if (STEP) set_step(1'b0);
    chk("halt_fetch_addr", 32'(addr_p), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk_quiet("halt_exec_strobes");
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_addr_p", 32'(addr_p), 32'd3);
      chk("halt_strobes", 32'({rf_we, ram_we, print_en}), 32'd0);
    end
    do_reset();
    chk("halt_cleared", 32'(halted), 32'd0);

    // Reset arriving before the STORE reaches EXEC
    rom[0] = 16'hA005;
    start();
    @(negedge clk);
    if (STEP) set_step(1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_store_ram_we", 32'(ram_we), 32'd0);
      chk("rst_store_addr_p", 32'(addr_p), 32'd0);
    end
    run = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_store_idle_ram_we", 32'(ram_we), 32'd0);
      chk("rst_store_idle_addr", 32'(addr_p), 32'd0);
    end

`ifdef SINGLE_STEP_EN
    // Three step pulses -> three instructions, extra pulses ignored mid-instruction
    do_reset();
    rom[0] = 16'h8004; rom[1] = 16'h1000; rom[2] = 16'hB000; rom[3] = 16'h0000;
    run_seq(3);
    chk("step_end_addr", 32'(addr_p), 32'd3);
    run = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("step_no_pulse_addr", 32'(addr_p), 32'd3);
      chk_quiet("step_no_pulse_quiet");
    end
    run = 1'b0;
`endif

    // Random programs against the ISA model
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 256; i++)
        rom[i] = {4'($urandom_range(0, 12)), 12'($urandom)};
      run_seq(80);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
